piso_shift_reg: RTL
===================

Name: piso_shift_reg

Overview:
- Parallel-in, serial-out shift register with a valid/ready load handshake.
- Accepts a WIDTH-bit word and emits it one bit per enabled clock, with a valid strobe and a last-bit marker.
- Serves as the transmit end of a serial bit-stream link in the sequential common-components library.
- Holds state when the shift enable is low, in the same way as the library's enabled flops.

Parameters:
- WIDTH, 8, word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  shift enable; when low, state and outputs hold.
- in_valid  input  1  upstream word available.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  parallel word, sampled on handshake.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out carries a valid bit.
- ser_last  output  1  current bit is the final bit of the word.
- busy  output  1  a word is in flight (state SHIFT).

Behaviour:
- Reset: clk and rst_n as already decided (one clock; reset asynchronous, active-low).
  - rst_n low forces, immediately and without a clock: state IDLE, shift register 0, bit counter 0, ser_out 0, ser_valid 0, ser_last 0, busy 0.
  - in_ready is 1 while in IDLE, including directly after reset release.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - in_ready = 1; ser_valid = 0; ser_out = 0; ser_last = 0.
  - Handshake at a posedge with in_valid & in_ready loads in_data, sets the counter to WIDTH-1 and moves to SHIFT.
  - The load is not gated by en.
- SHIFT:
  - ser_valid = 1 and busy = 1.
  - ser_out = shift_reg[WIDTH-1] when MSB_FIRST=1, else shift_reg[0]. The first bit is therefore visible in the cycle right after the handshake.
  - ser_last = 1 when counter == 0.
  - At a posedge with en = 1 and counter != 0: shift one position toward the output end, fill with 0, decrement the counter.
  - At a posedge with en = 1 and counter == 0, the word is complete:
    - if in_valid = 1, load the new word and stay in SHIFT (gapless back-to-back);
    - otherwise go to IDLE.
  - At a posedge with en = 0: hold everything, and keep ser_valid and ser_out stable.
- in_ready rule: in_ready = (state == IDLE) || (state == SHIFT && en && counter == 0).
  - in_ready is combinational from state, counter and en.
  - in_ready never depends on in_valid.
- Latency:
  - Handshake to first valid bit: 1 cycle.
  - A word occupies exactly WIDTH enabled cycles of ser_valid.
  - Back-to-back words give continuous ser_valid with no bubble.
- in_data is ignored outside a handshake. A word in flight is never corrupted by in_data changes.
- Counter width is $clog2(WIDTH). It never wraps below 0.
- Reset mid-word:
  - The word is dropped; no partial completion.
  - After release the block is in IDLE with in_ready = 1.
- Simultaneous en low and in_valid high on the last bit: no handshake, since in_ready = 0. The last bit holds.

Test Plan:
- Reset then idle: hold rst_n = 0 for 3 cycles, release -> ser_valid = 0, ser_out = 0, busy = 0, in_ready = 1; assert rst_n low asynchronously between edges -> outputs clear without waiting for a clock edge.
- Single word, MSB_FIRST = 1: en = 1, handshake in_data = 8'hA5 -> ser_out 1,0,1,0,0,1,0,1 over 8 cycles, ser_last only on the 8th, then IDLE with in_ready = 1.
- Stall: send 8'hC3 with en = 0 for 2 cycles after the 3rd bit -> the 3rd bit (0) holds for 3 cycles total, full sequence still 1,1,0,0,0,0,1,1, ser_valid never drops.
- Back-to-back: in_valid held high with 8'hF0 then 8'h0F -> 16 consecutive ser_valid cycles, in_ready pulses on the 8th bit, stream 11110000 00001111.
- Reset mid-word: assert rst_n low after 4 bits of 8'hFF -> ser_valid drops immediately; after release, new word 8'h81 transmits cleanly as 1,0,0,0,0,0,0,1.
- LSB-first build (MSB_FIRST = 0, WIDTH = 4): send 4'b1101 -> ser_out 1,0,1,1 with ser_last on the 4th bit.

Source files
------------

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in, serial-out shift register with a valid/ready
// load handshake. A WIDTH-bit word is emitted one bit per enabled clock,
// with a valid strobe and a last-bit marker. Back-to-back words stream
// without a bubble when the next word is offered on the final bit.
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             last_bit;
    logic             handshake;

    // The last bit of a word is on the line when the counter has run down.
    assign last_bit  = (cnt == '0);

    // A word can be taken when idle, or on an enabled final bit so the
    // next word follows with no gap; never depends on in_valid.
    assign in_ready  = (state == IDLE) || ((state == SHIFT) && en && last_bit);
    assign handshake = in_valid && in_ready;

    // State, shift register and counter; reset drops any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            cnt       <= cnt_next;
        end
    end

    // Next-state logic: load on handshake, shift on enable, hold otherwise.
    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (handshake) begin
                    shift_next = in_data;
                    cnt_next   = CW'(WIDTH - 1);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    if (!last_bit) begin
                        if (MSB_FIRST) begin
                            shift_next = {shift_reg[WIDTH-2:0], 1'b0};
                        end else begin
                            shift_next = {1'b0, shift_reg[WIDTH-1:1]};
                        end
                        cnt_next = cnt - CW'(1);
                    end else if (handshake) begin
                        shift_next = in_data;
                        cnt_next   = CW'(WIDTH - 1);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Serial outputs are driven only while a word is in flight.
    always_comb begin
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        ser_last  = 1'b0;
        busy      = 1'b0;
        if (state == SHIFT) begin
            ser_out   = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
            ser_valid = 1'b1;
            ser_last  = last_bit;
            busy      = 1'b1;
        end
    end

endmodule
